// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and uart_controller-side signals of the TX arbiter, grouped as one bus.
// master = producers/uart_controller side, slave = the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int P_DATA_W = 40,
    parameter int P_CNT_W  = 8
);
    logic [P_DATA_W-1:0] i_A_DATA;
    logic                i_A_VALID;
    logic [P_DATA_W-1:0] i_M_DATA;
    logic                i_M_VALID;
    logic [P_DATA_W-1:0] o_UART_DATA_TX;
    logic                o_UART_DATA_TX_VALID;
    logic                i_UART_DATA_TX_READY;
    logic                i_CLEAR_STATS;
    logic [P_CNT_W-1:0]  o_A_DROP_CNT;
    logic [P_CNT_W-1:0]  o_M_DROP_CNT;
    logic [1:0]          o_ACTIVE_SRC;
    logic                o_BUSY;

    modport master (
        output i_A_DATA, i_A_VALID, i_M_DATA, i_M_VALID,
        output i_UART_DATA_TX_READY, i_CLEAR_STATS,
        input  o_UART_DATA_TX, o_UART_DATA_TX_VALID,
        input  o_A_DROP_CNT, o_M_DROP_CNT, o_ACTIVE_SRC, o_BUSY
    );

    modport slave (
        input  i_A_DATA, i_A_VALID, i_M_DATA, i_M_VALID,
        input  i_UART_DATA_TX_READY, i_CLEAR_STATS,
        output o_UART_DATA_TX, o_UART_DATA_TX_VALID,
        output o_A_DROP_CNT, o_M_DROP_CNT, o_ACTIVE_SRC, o_BUSY
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX word channel between producers A and M, one holding word each.
// Latency: pulse at t -> holder set at t+1 -> TX valid with the word at t+2.
// Backpressure: producers have none; a pulse into a full holder is dropped and counted.
module uart_tx_arbiter #(
    parameter int P_DATA_W        = 40,
    parameter int P_PRIORITY_MODE = 0,
    parameter int P_CNT_W         = 8
) (
    input  logic         i_CLK,
    input  logic         i_RST,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    localparam logic [P_CNT_W-1:0] CNT_ONE = P_CNT_W'(1);

    state_t              state;
    logic                h_a;
    logic                h_m;
    logic [P_DATA_W-1:0] h_a_dat;
    logic [P_DATA_W-1:0] h_m_dat;
    logic                last_grant_a;
    logic [P_DATA_W-1:0] out_dat;
    logic                out_vld;
    logic [1:0]          active_src;
    logic [P_CNT_W-1:0]  a_drop_cnt;
    logic [P_CNT_W-1:0]  m_drop_cnt;

    logic grant_a;
    logic grant_m;
    logic drop_a;
    logic drop_m;

    // Grants are only issued from IDLE, which enforces one idle cycle between words.
    always_comb begin
        grant_a = 1'b0;
        grant_m = 1'b0;
        if (state == ST_IDLE) begin
            if (h_a && h_m) begin
                if (P_PRIORITY_MODE != 0 || !last_grant_a) begin
                    grant_a = 1'b1;
                end else begin
                    grant_m = 1'b1;
                end
            end else begin
                grant_a = h_a;
                grant_m = h_m;
            end
        end
    end

    assign drop_a = bus.i_A_VALID && h_a && !grant_a;
    assign drop_m = bus.i_M_VALID && h_m && !grant_m;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state        <= ST_IDLE;
            h_a          <= 1'b0;
            h_m          <= 1'b0;
            h_a_dat      <= '0;
            h_m_dat      <= '0;
            last_grant_a <= 1'b0;
            out_dat      <= '0;
            out_vld      <= 1'b0;
            active_src   <= 2'b00;
            a_drop_cnt   <= '0;
            m_drop_cnt   <= '0;
        end else begin
            // A holder emptied by this cycle's grant can take a new word immediately.
            if (bus.i_A_VALID && (!h_a || grant_a)) begin
                h_a     <= 1'b1;
                h_a_dat <= bus.i_A_DATA;
            end else if (grant_a) begin
                h_a <= 1'b0;
            end

            if (bus.i_M_VALID && (!h_m || grant_m)) begin
                h_m     <= 1'b1;
                h_m_dat <= bus.i_M_DATA;
            end else if (grant_m) begin
                h_m <= 1'b0;
            end

            if (bus.i_CLEAR_STATS) begin
                a_drop_cnt <= '0;
                m_drop_cnt <= '0;
            end else begin
                if (drop_a && a_drop_cnt != '1) a_drop_cnt <= a_drop_cnt + CNT_ONE;
                if (drop_m && m_drop_cnt != '1) m_drop_cnt <= m_drop_cnt + CNT_ONE;
            end

            case (state)
                ST_IDLE: begin
                    if (grant_a || grant_m) begin
                        out_dat      <= grant_a ? h_a_dat : h_m_dat;
                        out_vld      <= 1'b1;
                        active_src   <= grant_a ? 2'b01 : 2'b10;
                        last_grant_a <= grant_a;
                        state        <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.i_UART_DATA_TX_READY) begin
                        out_vld    <= 1'b0;
                        active_src <= 2'b00;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_UART_DATA_TX       = out_dat;
    assign bus.o_UART_DATA_TX_VALID = out_vld;
    assign bus.o_ACTIVE_SRC         = active_src;
    assign bus.o_A_DROP_CNT         = a_drop_cnt;
    assign bus.o_M_DROP_CNT         = m_drop_cnt;
    assign bus.o_BUSY               = h_a | h_m | (state == ST_SEND);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_uart_tx_arbiter;
    localparam int DW = 40;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.P_DATA_W(DW), .P_CNT_W(CW)) bus0 ();
    uart_tx_arbiter_if #(.P_DATA_W(DW), .P_CNT_W(CW)) bus1 ();

    uart_tx_arbiter #(.P_DATA_W(DW), .P_PRIORITY_MODE(0), .P_CNT_W(CW)) dut0 (
        .i_CLK(clk), .i_RST(rst), .bus(bus0));
    uart_tx_arbiter #(.P_DATA_W(DW), .P_PRIORITY_MODE(1), .P_CNT_W(CW)) dut1 (
        .i_CLK(clk), .i_RST(rst), .bus(bus1));

    // Reference model, one per DUT; source index 0 = A, 1 = M.
    logic          m_h    [2][2];
    logic [DW-1:0] m_hd   [2][2];
    int            m_cnt  [2][2];
    bit            m_send [2];
    logic [DW-1:0] m_out  [2];
    int            m_src  [2];
    int            m_last [2];

    always @(posedge clk) begin : ref_model
        logic          v   [2][2];
        logic [DW-1:0] d   [2][2];
        logic          rdy [2];
        logic          clr [2];
        int            g;
        v[0][0] = bus0.i_A_VALID; d[0][0] = bus0.i_A_DATA;
        v[0][1] = bus0.i_M_VALID; d[0][1] = bus0.i_M_DATA;
        v[1][0] = bus1.i_A_VALID; d[1][0] = bus1.i_A_DATA;
        v[1][1] = bus1.i_M_VALID; d[1][1] = bus1.i_M_DATA;
        rdy[0] = bus0.i_UART_DATA_TX_READY; clr[0] = bus0.i_CLEAR_STATS;
        rdy[1] = bus1.i_UART_DATA_TX_READY; clr[1] = bus1.i_CLEAR_STATS;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int s = 0; s < 2; s++) begin
                    m_h[k][s] = 1'b0; m_hd[k][s] = '0; m_cnt[k][s] = 0;
                end
                m_send[k] = 1'b0; m_out[k] = '0; m_src[k] = 0; m_last[k] = 1;
            end else begin
                g = -1;
                if (!m_send[k]) begin
                    if (m_h[k][0] && m_h[k][1]) g = (k == 1) ? 0 : ((m_last[k] == 0) ? 1 : 0);
                    else if (m_h[k][0]) g = 0;
                    else if (m_h[k][1]) g = 1;
                end
                if (g >= 0) begin
                    m_out[k] = m_hd[k][g]; m_src[k] = g + 1; m_last[k] = g;
                    m_send[k] = 1'b1; m_h[k][g] = 1'b0;
                end else if (m_send[k] && rdy[k]) begin
                    m_send[k] = 1'b0; m_src[k] = 0;
                end
                for (int s = 0; s < 2; s++) begin
                    if (v[k][s]) begin
                        if (!m_h[k][s]) begin
                            m_h[k][s] = 1'b1; m_hd[k][s] = d[k][s];
                        end else if (m_cnt[k][s] < 255) begin
                            m_cnt[k][s] = m_cnt[k][s] + 1;
                        end
                    end
                end
                if (clr[k]) begin
                    m_cnt[k][0] = 0; m_cnt[k][1] = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand40();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic clear_inputs();
        bus0.i_A_VALID = 0; bus0.i_M_VALID = 0; bus0.i_A_DATA = '0; bus0.i_M_DATA = '0;
        bus0.i_UART_DATA_TX_READY = 0; bus0.i_CLEAR_STATS = 0;
        bus1.i_A_VALID = 0; bus1.i_M_VALID = 0; bus1.i_A_DATA = '0; bus1.i_M_DATA = '0;
        bus1.i_UART_DATA_TX_READY = 0; bus1.i_CLEAR_STATS = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus0.o_UART_DATA_TX_VALID !== 1'b0 || bus0.o_UART_DATA_TX !== '0 ||
            bus0.o_ACTIVE_SRC !== 2'b00 || bus0.o_BUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: vld=%b dat=%h src=%b busy=%b, want all zero",
                     bus0.o_UART_DATA_TX_VALID, bus0.o_UART_DATA_TX, bus0.o_ACTIVE_SRC, bus0.o_BUSY);
        end
        n_checks++;
        if (bus0.o_A_DROP_CNT !== 8'h00 || bus0.o_M_DROP_CNT !== 8'h00 ||
            bus1.o_A_DROP_CNT !== 8'h00 || bus1.o_BUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_counters: a0=%h m0=%h a1=%h busy1=%b, want zero",
                     bus0.o_A_DROP_CNT, bus0.o_M_DROP_CNT, bus1.o_A_DROP_CNT, bus1.o_BUSY);
        end
    endtask

    task automatic test_single_a();
        bus0.i_UART_DATA_TX_READY = 1;
        bus0.i_A_DATA = 40'h00_1122_3344;
        bus0.i_A_VALID = 1;
        cyc();
        bus0.i_A_VALID = 0;
        n_checks++;
        if (bus0.o_UART_DATA_TX_VALID !== 1'b0 || bus0.o_BUSY !== 1'b1) begin
            n_errors++;
            $display("FAIL single_t1: vld=%b busy=%b, want vld=0 busy=1",
                     bus0.o_UART_DATA_TX_VALID, bus0.o_BUSY);
        end
        cyc();
        n_checks++;
        if (bus0.o_UART_DATA_TX_VALID !== 1'b1 || bus0.o_UART_DATA_TX !== 40'h00_1122_3344 ||
            bus0.o_ACTIVE_SRC !== 2'b01) begin
            n_errors++;
            $display("FAIL single_t2: vld=%b dat=%h src=%b, want 1 0011223344 01",
                     bus0.o_UART_DATA_TX_VALID, bus0.o_UART_DATA_TX, bus0.o_ACTIVE_SRC);
        end
        cyc();
        n_checks++;
        if (bus0.o_UART_DATA_TX_VALID !== 1'b0 || bus0.o_ACTIVE_SRC !== 2'b00 ||
            bus0.o_A_DROP_CNT !== 8'h00 || bus0.o_M_DROP_CNT !== 8'h00) begin
            n_errors++;
            $display("FAIL single_t3: vld=%b src=%b acnt=%h mcnt=%h, want 0 00 00 00",
                     bus0.o_UART_DATA_TX_VALID, bus0.o_ACTIVE_SRC, bus0.o_A_DROP_CNT, bus0.o_M_DROP_CNT);
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] got_d [$];
        logic [1:0]    got_s [$];
        logic [DW-1:0] exp_d [4];
        logic [1:0]    exp_s [4];
        exp_d = '{40'h0A, 40'h0B, 40'h1A, 40'h1B};
        exp_s = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        bus0.i_UART_DATA_TX_READY = 1;
        for (int p = 0; p < 2; p++) begin
            bus0.i_A_DATA = (p == 0) ? 40'h0A : 40'h1A;
            bus0.i_M_DATA = (p == 0) ? 40'h0B : 40'h1B;
            bus0.i_A_VALID = 1; bus0.i_M_VALID = 1;
            cyc();
            bus0.i_A_VALID = 0; bus0.i_M_VALID = 0;
            for (int i = 0; i < 6; i++) begin
                if (bus0.o_UART_DATA_TX_VALID) begin
                    got_d.push_back(bus0.o_UART_DATA_TX);
                    got_s.push_back(bus0.o_ACTIVE_SRC);
                end
                cyc();
            end
        end
        n_checks++;
        if (got_d.size() != 4) begin
            n_errors++;
            $display("FAIL simul_count: got %0d words, want 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
                    n_errors++;
                    $display("FAIL simul_order[%0d]: dat=%h src=%b, want %h %b",
                             i, got_d[i], got_s[i], exp_d[i], exp_s[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got_d [$];
        int            bad;
        do_reset();
        bus0.i_A_DATA = 40'hA1_0000_0001; bus0.i_A_VALID = 1;
        cyc();
        bus0.i_A_VALID = 0;
        cyc();
        bus0.i_A_DATA = 40'hA2_0000_0002; bus0.i_A_VALID = 1;
        cyc();
        bus0.i_A_DATA = 40'hA3_0000_0003;
        cyc();
        bus0.i_A_VALID = 0;
        n_checks++;
        if (bus0.o_A_DROP_CNT !== 8'h01 || bus0.o_M_DROP_CNT !== 8'h00) begin
            n_errors++;
            $display("FAIL bp_dropcnt: a=%h m=%h, want 01 00", bus0.o_A_DROP_CNT, bus0.o_M_DROP_CNT);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus0.o_UART_DATA_TX_VALID !== 1'b1 || bus0.o_UART_DATA_TX !== 40'hA1_0000_0001) bad++;
            cyc();
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL bp_stable: %0d unstable cycles, want 0", bad);
        end
        bus0.i_UART_DATA_TX_READY = 1;
        for (int i = 0; i < 6; i++) begin
            if (bus0.o_UART_DATA_TX_VALID) got_d.push_back(bus0.o_UART_DATA_TX);
            cyc();
        end
        n_checks++;
        if (got_d.size() != 2 || got_d[0] !== 40'hA1_0000_0001 || got_d[1] !== 40'hA2_0000_0002) begin
            n_errors++;
            $display("FAIL bp_order: got %0d words first=%h, want A1 then A2",
                     got_d.size(), (got_d.size() > 0) ? got_d[0] : 40'h0);
        end
    endtask

    task automatic test_fixed_priority();
        logic [DW-1:0] got_d [$];
        logic [DW-1:0] exp_d [6];
        int            ai;
        exp_d = '{40'hA0, 40'hA1, 40'hA2, 40'hEE, 40'hA3, 40'hA4};
        do_reset();
        bus1.i_UART_DATA_TX_READY = 1;
        ai = 0;
        for (int i = 0; i < 20; i++) begin
            bus1.i_A_VALID = (i == 0 || i == 1 || i == 4 || i == 7 || i == 10);
            bus1.i_A_DATA  = 40'hA0 + DW'(ai);
            if (bus1.i_A_VALID) ai++;
            bus1.i_M_VALID = (i == 0);
            bus1.i_M_DATA  = 40'hEE;
            if (bus1.o_UART_DATA_TX_VALID) got_d.push_back(bus1.o_UART_DATA_TX);
            cyc();
        end
        bus1.i_A_VALID = 0; bus1.i_M_VALID = 0;
        n_checks++;
        if (got_d.size() != 6) begin
            n_errors++;
            $display("FAIL prio_count: got %0d words, want 6", got_d.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_d[i] !== exp_d[i]) begin
                    n_errors++;
                    $display("FAIL prio_order[%0d]: dat=%h, want %h", i, got_d[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus0.i_A_VALID = 1;
        for (int i = 0; i < 302; i++) begin
            bus0.i_A_DATA = rand40();
            cyc();
        end
        n_checks++;
        if (bus0.o_A_DROP_CNT !== 8'hFF || bus0.o_M_DROP_CNT !== 8'h00) begin
            n_errors++;
            $display("FAIL sat_value: a=%h m=%h, want ff 00", bus0.o_A_DROP_CNT, bus0.o_M_DROP_CNT);
        end
        bus0.i_CLEAR_STATS = 1;
        cyc();
        bus0.i_CLEAR_STATS = 0;
        bus0.i_A_VALID = 0;
        n_checks++;
        if (bus0.o_A_DROP_CNT !== 8'h00) begin
            n_errors++;
            $display("FAIL sat_clear: a=%h, want 00", bus0.o_A_DROP_CNT);
        end
    endtask

    task automatic test_reset_in_send();
        int waited;
        do_reset();
        bus0.i_A_DATA = 40'h55_0000_0001; bus0.i_A_VALID = 1;
        cyc();
        bus0.i_A_VALID = 0;
        bus0.i_M_DATA = 40'h66_0000_0001; bus0.i_M_VALID = 1;
        cyc();
        bus0.i_M_VALID = 0;
        waited = 0;
        while (bus0.o_UART_DATA_TX_VALID !== 1'b1 && waited < 20) begin
            cyc();
            waited++;
        end
        n_checks++;
        if (bus0.o_UART_DATA_TX_VALID !== 1'b1) begin
            n_errors++;
            $display("FAIL rstsend_wait: vld=%b after %0d cycles, want 1", bus0.o_UART_DATA_TX_VALID, waited);
        end
        rst = 1'b1;
        bus0.i_A_VALID = 1; bus0.i_A_DATA = 40'h77_0000_0001;
        cyc();
        rst = 1'b0;
        bus0.i_A_VALID = 0;
        n_checks++;
        if (bus0.o_UART_DATA_TX_VALID !== 1'b0 || bus0.o_BUSY !== 1'b0 || bus0.o_ACTIVE_SRC !== 2'b00) begin
            n_errors++;
            $display("FAIL rstsend_clear: vld=%b busy=%b src=%b, want 0 0 00",
                     bus0.o_UART_DATA_TX_VALID, bus0.o_BUSY, bus0.o_ACTIVE_SRC);
        end
        bus0.i_UART_DATA_TX_READY = 1;
        bus0.i_A_DATA = 40'h88_0000_0002; bus0.i_A_VALID = 1;
        cyc();
        bus0.i_A_VALID = 0;
        cyc();
        n_checks++;
        if (bus0.o_UART_DATA_TX_VALID !== 1'b1 || bus0.o_UART_DATA_TX !== 40'h88_0000_0002) begin
            n_errors++;
            $display("FAIL rstsend_after: vld=%b dat=%h, want 1 8800000002",
                     bus0.o_UART_DATA_TX_VALID, bus0.o_UART_DATA_TX);
        end
    endtask

    task automatic test_random();
        logic          d_vld;
        logic [DW-1:0] d_dat;
        logic [1:0]    d_src;
        logic          d_busy;
        logic [CW-1:0] d_ca;
        logic [CW-1:0] d_cm;
        logic          e_busy;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            bus0.i_A_VALID = ($urandom_range(0, 9) < 4); bus0.i_A_DATA = rand40();
            bus0.i_M_VALID = ($urandom_range(0, 9) < 4); bus0.i_M_DATA = rand40();
            bus0.i_UART_DATA_TX_READY = $urandom_range(0, 1);
            bus0.i_CLEAR_STATS = ($urandom_range(0, 49) == 0);
            bus1.i_A_VALID = ($urandom_range(0, 9) < 4); bus1.i_A_DATA = rand40();
            bus1.i_M_VALID = ($urandom_range(0, 9) < 4); bus1.i_M_DATA = rand40();
            bus1.i_UART_DATA_TX_READY = $urandom_range(0, 1);
            bus1.i_CLEAR_STATS = ($urandom_range(0, 49) == 0);
            cyc();
            for (int k = 0; k < 2; k++) begin
                d_vld  = (k == 0) ? bus0.o_UART_DATA_TX_VALID : bus1.o_UART_DATA_TX_VALID;
                d_dat  = (k == 0) ? bus0.o_UART_DATA_TX       : bus1.o_UART_DATA_TX;
                d_src  = (k == 0) ? bus0.o_ACTIVE_SRC         : bus1.o_ACTIVE_SRC;
                d_busy = (k == 0) ? bus0.o_BUSY               : bus1.o_BUSY;
                d_ca   = (k == 0) ? bus0.o_A_DROP_CNT         : bus1.o_A_DROP_CNT;
                d_cm   = (k == 0) ? bus0.o_M_DROP_CNT         : bus1.o_M_DROP_CNT;
                e_busy = m_h[k][0] | m_h[k][1] | m_send[k];
                n_checks++;
                if (d_vld !== m_send[k] || d_dat !== m_out[k] || d_src !== 2'(m_src[k])) begin
                    n_errors++;
                    $display("FAIL rand_out dut%0d cyc%0d: vld=%b dat=%h src=%b, want %b %h %0d",
                             k, i, d_vld, d_dat, d_src, m_send[k], m_out[k], m_src[k]);
                end
                n_checks++;
                if (d_busy !== e_busy || d_ca !== 8'(m_cnt[k][0]) || d_cm !== 8'(m_cnt[k][1])) begin
                    n_errors++;
                    $display("FAIL rand_stat dut%0d cyc%0d: busy=%b a=%h m=%h, want %b %0d %0d",
                             k, i, d_busy, d_ca, d_cm, e_busy, m_cnt[k][0], m_cnt[k][1]);
                end
            end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        cyc();
        test_reset();
        test_single_a();
        test_simultaneous();
        test_backpressure();
        test_fixed_priority();
        test_saturation();
        test_reset_in_send();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
